// File: rtl/edge_cfg_initiator.sv
`default_nettype none
// ============================================================================
// edge_cfg_initiator : programs an edge engine over a pipelined slave bus,
// launches a frame and polls its status until done or timeout.  Rev 1.0
// ============================================================================
module edge_cfg_initiator #(
   parameter logic [31:0] POLL_LIMIT = 32'd1_000_000,
   parameter logic [31:0] BUSY_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [15:0] cfg_width,
   input  logic [15:0] cfg_height,
   input  logic [31:0] cfg_raddr,
   input  logic [31:0] cfg_waddr,
   output logic [31:0] s_haddr,
   output logic        s_hwrite,
   output logic [31:0] s_hwdata,
   input  logic [31:0] s_hrdata,
   input  logic        s_hready,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_A_SIZE  = 3'd1;
   localparam logic [2:0] S_A_RADDR = 3'd2;
   localparam logic [2:0] S_A_WADDR = 3'd3;
   localparam logic [2:0] S_A_START = 3'd4;
   localparam logic [2:0] S_POLL    = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   // r_dp holds the state whose address phase is now in its data phase
   logic [2:0]  r_dp;
   logic [15:0] r_width;
   logic [15:0] r_height;
   logic [31:0] r_raddr;
   logic [31:0] r_waddr;
   logic [31:0] r_poll_cnt;
   logic        r_done;
   logic        r_error;

   logic        w_cfg_ok;
   logic        w_accept;
   logic        w_reject;
   logic        w_stall;
   logic        w_sample;
   logic        w_stat_busy;
   logic        w_finish;
   logic        w_timeout;
   logic [31:0] w_poll_next;
   logic [31:0] w_area;
   logic [31:0] w_last_addr;

   assign w_cfg_ok    = (cfg_width >= 16'd3) && (cfg_height >= 16'd3);
   assign w_accept    = !n_rst && (r_state == S_IDLE) && start && w_cfg_ok;
   assign w_reject    = (r_state == S_IDLE) && start && !w_cfg_ok;
   assign w_stall     = (r_dp != S_IDLE) && !s_hready;
   assign w_sample    = (r_state == S_POLL) && (r_dp == S_POLL) && s_hready;
   assign w_stat_busy = (s_hrdata == BUSY_WORD);
   assign w_poll_next = r_poll_cnt + 32'd1;
   assign w_finish    = w_sample && !w_stat_busy;
   assign w_timeout   = w_sample && w_stat_busy && (w_poll_next >= POLL_LIMIT);
   // Interior-pixel count; the engine wants the address of the last output word
   assign w_area      = ({16'd0, r_width} - 32'd2) * ({16'd0, r_height} - 32'd2);
   assign w_last_addr = r_waddr - 32'd1 + w_area;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (!w_stall) begin
         case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_A_SIZE;
            S_A_SIZE:  w_state_next = S_A_RADDR;
            S_A_RADDR: w_state_next = S_A_WADDR;
            S_A_WADDR: w_state_next = S_A_START;
            S_A_START: w_state_next = S_POLL;
            S_POLL:    if (w_finish || w_timeout) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_dp       <= S_IDLE;
         r_width    <= 16'd0;
         r_height   <= 16'd0;
         r_raddr    <= 32'd0;
         r_waddr    <= 32'd0;
         r_poll_cnt <= 32'd0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_done  <= w_finish;
         r_error <= w_reject || w_timeout;
         if (w_accept) begin
            r_width    <= cfg_width;
            r_height   <= cfg_height;
            r_raddr    <= cfg_raddr;
            r_waddr    <= cfg_waddr;
            r_poll_cnt <= 32'd0;
         end else if (w_sample && w_stat_busy) begin
            r_poll_cnt <= w_poll_next;
         end
         // A read issued in the final poll cycle is abandoned on return to idle
         if (!w_stall) begin
            r_dp <= (w_state_next == S_IDLE) ? S_IDLE : r_state;
         end
      end
   end

   always_comb begin
      s_haddr  = 32'd0;
      s_hwrite = 1'b0;
      s_hwdata = 32'd0;
      busy     = (r_state != S_IDLE) || w_accept;
      done     = r_done;
      error    = r_error;
      case (r_state)
         S_A_SIZE:  begin s_haddr = 32'd1; s_hwrite = 1'b1; end
         S_A_RADDR: begin s_haddr = 32'd3; s_hwrite = 1'b1; end
         S_A_WADDR: begin s_haddr = 32'd2; s_hwrite = 1'b1; end
         S_A_START: begin s_haddr = 32'd0; s_hwrite = 1'b1; end
         default:   begin s_haddr = 32'd0; s_hwrite = 1'b0; end
      endcase
      case (r_dp)
         S_A_SIZE:  s_hwdata = {r_width, r_height};
         S_A_RADDR: s_hwdata = r_raddr;
         S_A_WADDR: s_hwdata = w_last_addr;
         S_A_START: s_hwdata = 32'd1;
         default:   s_hwdata = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_edge_cfg_initiator.sv
`default_nettype none
// ============================================================================
// tb_edge_cfg_initiator : transaction-level model of the configure/poll frame,
// directed scenarios plus randomized traffic.  Rev 1.0
// ============================================================================
module tb_edge_cfg_initiator;

   localparam int          LIMIT = 4;
   localparam logic [31:0] BUSYW = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        n_rst, start, s_hwrite, s_hready, busy, done, error;
   logic [15:0] cfg_width, cfg_height;
   logic [31:0] cfg_raddr, cfg_waddr, s_haddr, s_hwdata, s_hrdata;

   always #5 clk = ~clk;

   edge_cfg_initiator #(.POLL_LIMIT(32'd4), .BUSY_WORD(32'hFFFF_FFFF)) dut (
      .clk(clk), .n_rst(n_rst), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_raddr(cfg_raddr), .cfg_waddr(cfg_waddr),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
      .s_hrdata(s_hrdata), .s_hready(s_hready),
      .busy(busy), .done(done), .error(error)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: four configuration writes, then endless status reads
   bit          armed = 0;
   bit          m_active = 0, m_dp_valid = 0, m_dp_write = 0, m_done_p = 0, m_err_p = 0;
   int          m_idx = 0, m_fs = 0, m_samples_total = 0;
   logic [31:0] m_dp_data = 0;
   logic [31:0] m_wd [4];
   logic [31:0] m_wa [4] = '{32'd1, 32'd3, 32'd2, 32'd0};

   // Observations of the DUT for scenario-level checks
   int          n_busy = 0, n_done = 0, n_error = 0, n_h2w1 = 0;
   bit          obs_v = 0;
   logic [31:0] obs_a = 0;
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   always @(negedge clk) begin
      bit          accept, fin;
      logic [31:0] e_haddr, e_hwdata;
      logic        e_hwrite, e_busy;
      accept   = !n_rst && !m_active && start && (cfg_width >= 3) && (cfg_height >= 3);
      e_haddr  = 32'd0;
      e_hwrite = 1'b0;
      if (m_active && m_idx < 4) begin
         e_haddr  = m_wa[m_idx];
         e_hwrite = 1'b1;
      end
      e_hwdata = (m_active && m_dp_valid && m_dp_write) ? m_dp_data : 32'd0;
      e_busy   = m_active || accept;
      if (armed) begin
         chk("haddr",  s_haddr, e_haddr);
         chk("hwrite", {31'd0, s_hwrite}, {31'd0, e_hwrite});
         chk("hwdata", s_hwdata, e_hwdata);
         chk("busy",   {31'd0, busy},  {31'd0, e_busy});
         chk("done",   {31'd0, done},  {31'd0, m_done_p});
         chk("error",  {31'd0, error}, {31'd0, m_err_p});
         n_busy  += int'(busy);
         n_done  += int'(done);
         n_error += int'(error);
         if (s_haddr == 32'd2 && s_hwdata == 32'd1) n_h2w1++;
         if (obs_v && s_hready) begin
            log_addr.push_back(obs_a);
            log_data.push_back(s_hwdata);
         end
      end
      if (n_rst) begin
         obs_v = 0;
      end else if (!(obs_v && !s_hready)) begin
         obs_v = s_hwrite;
         obs_a = s_haddr;
      end

      if (n_rst) begin
         m_active = 0; m_dp_valid = 0; m_done_p = 0; m_err_p = 0;
         armed = 1;
      end else begin
         m_done_p = 0;
         m_err_p  = 0;
         if (!m_active) begin
            if (start) begin
               if (cfg_width >= 3 && cfg_height >= 3) begin
                  m_wd[0] = {cfg_width, cfg_height};
                  m_wd[1] = cfg_raddr;
                  m_wd[2] = cfg_waddr - 32'd1 + (32'(cfg_width) - 32'd2) * (32'(cfg_height) - 32'd2);
                  m_wd[3] = 32'd1;
                  m_active = 1; m_idx = 0; m_dp_valid = 0; m_fs = 0;
               end else begin
                  m_err_p = 1;
               end
            end
         end else if (!(m_dp_valid && !s_hready)) begin
            fin = 0;
            if (m_dp_valid && !m_dp_write) begin
               m_fs++;
               m_samples_total++;
               if (s_hrdata != BUSYW) begin
                  m_done_p = 1; fin = 1;
               end else if (m_fs >= LIMIT) begin
                  m_err_p = 1; fin = 1;
               end
            end
            if (fin) begin
               m_active = 0; m_dp_valid = 0;
            end else begin
               m_dp_valid = 1;
               if (m_idx < 4) begin
                  m_dp_write = 1; m_dp_data = m_wd[m_idx]; m_idx++;
               end else begin
                  m_dp_write = 0;
               end
            end
         end
      end
   end

   // Status responder: busy for busy_n samples of the frame, then ready
   bit rd_random = 0;
   int busy_n = 0;

   task automatic step();
      @(posedge clk);
      #1;
      if (rd_random) s_hrdata = ($urandom_range(0, 1) == 1) ? BUSYW : $urandom();
      else           s_hrdata = (m_fs < busy_n) ? BUSYW : 32'h0;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (m_active && n < maxc) begin
         step();
         n++;
      end
      if (n >= maxc) chk("frame_timeout", 32'd1, 32'd0);
      step();
      step();
   endtask

   task automatic check_seq(input int base, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2);
      logic [31:0] ea [4];
      logic [31:0] ed [4];
      ea = '{32'd1, 32'd3, 32'd2, 32'd0};
      ed = '{d0, d1, d2, 32'd1};
      for (int i = 0; i < 4; i++) begin
         if (base + i < log_addr.size()) begin
            chk("seq_addr", log_addr[base + i], ea[i]);
            chk("seq_data", log_data[base + i], ed[i]);
         end else begin
            chk("seq_missing", 32'd0, 32'd1);
         end
      end
   endtask

   task automatic launch(input logic [15:0] w, input logic [15:0] h,
                         input logic [31:0] r, input logic [31:0] wa);
      cfg_width = w; cfg_height = h; cfg_raddr = r; cfg_waddr = wa;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int b_log, b_done, b_err, b_busy, b_h, b_samp;
      n_rst = 1'b1; start = 1'b0; s_hready = 1'b1; s_hrdata = 32'h0;
      cfg_width = 16'd0; cfg_height = 16'd0; cfg_raddr = 32'd0; cfg_waddr = 32'd0;
      repeat (3) step();
      n_rst = 1'b0;
      step();
      chk("rst_haddr",  s_haddr, 32'd0);
      chk("rst_hwrite", {31'd0, s_hwrite}, 32'd0);
      chk("rst_hwdata", s_hwdata, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_error",  {31'd0, error}, 32'd0);

      // Basic frame, three busy polls
      b_log = log_addr.size(); b_done = n_done; b_err = n_error; b_busy = n_busy;
      busy_n = 3;
      launch(16'd100, 16'd50, 32'd1, 32'd200000);
      wait_idle(60);
      chk("a_model_waddr", m_wd[2], 32'd204703);
      chk("a_writes", 32'(log_addr.size() - b_log), 32'd4);
      check_seq(b_log, {16'd100, 16'd50}, 32'd1, 32'd204703);
      chk("a_done",  32'(n_done - b_done), 32'd1);
      chk("a_error", 32'(n_error - b_err), 32'd0);
      chk("a_busy_cycles", 32'(n_busy - b_busy), 32'd10);

      // Two wait states in the raddr data phase
      b_log = log_addr.size(); b_done = n_done; b_h = n_h2w1;
      launch(16'd100, 16'd50, 32'd1, 32'd200000);
      step();
      step();
      s_hready = 1'b0;
      step();
      step();
      s_hready = 1'b1;
      wait_idle(60);
      chk("b_hold_cycles", 32'(n_h2w1 - b_h), 32'd3);
      check_seq(b_log, {16'd100, 16'd50}, 32'd1, 32'd204703);
      chk("b_done", 32'(n_done - b_done), 32'd1);

      // Too-narrow image is rejected
      b_log = log_addr.size(); b_done = n_done; b_err = n_error; b_busy = n_busy;
      launch(16'd2, 16'd50, 32'd7, 32'd9);
      step();
      step();
      chk("c_error", 32'(n_error - b_err), 32'd1);
      chk("c_done",  32'(n_done - b_done), 32'd0);
      chk("c_busy",  32'(n_busy - b_busy), 32'd0);
      chk("c_writes", 32'(log_addr.size() - b_log), 32'd0);

      // Status stuck busy: poll limit
      b_done = n_done; b_err = n_error; b_samp = m_samples_total;
      busy_n = 1000;
      launch(16'd100, 16'd50, 32'd1, 32'd200000);
      wait_idle(60);
      chk("d_samples", 32'(m_samples_total - b_samp), 32'd4);
      chk("d_error", 32'(n_error - b_err), 32'd1);
      chk("d_done",  32'(n_done - b_done), 32'd0);

      // Second start while polling is ignored
      b_log = log_addr.size(); b_done = n_done;
      busy_n = 3;
      launch(16'd20, 16'd10, 32'h1000, 32'h2000);
      repeat (6) step();
      launch(16'd40, 16'd40, 32'h5555, 32'h6666);
      wait_idle(60);
      chk("e_writes", 32'(log_addr.size() - b_log), 32'd4);
      check_seq(b_log, {16'd20, 16'd10}, 32'h1000, 32'h2000 - 32'd1 + 32'd144);
      chk("e_done", 32'(n_done - b_done), 32'd1);

      // Reset during the waddr address phase, then a fresh frame
      b_done = n_done; b_err = n_error;
      launch(16'd100, 16'd50, 32'd1, 32'd200000);
      step();
      step();
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
      chk("f_haddr",  s_haddr, 32'd0);
      chk("f_hwrite", {31'd0, s_hwrite}, 32'd0);
      chk("f_hwdata", s_hwdata, 32'd0);
      chk("f_busy",   {31'd0, busy}, 32'd0);
      step();
      step();
      chk("f_no_pulse", 32'(n_done - b_done + n_error - b_err), 32'd0);
      b_log = log_addr.size();
      busy_n = 2;
      launch(16'd3, 16'd3, 32'hAAAA_0000, 32'h0);
      wait_idle(60);
      check_seq(b_log, {16'd3, 16'd3}, 32'hAAAA_0000, 32'h0);
      chk("f_done", 32'(n_done - b_done), 32'd1);

      // Randomized traffic
      rd_random = 1;
      for (int i = 0; i < 4000; i++) begin
         step();
         n_rst      = ($urandom_range(0, 299) == 0);
         start      = ($urandom_range(0, 7) == 0);
         cfg_width  = 16'($urandom_range(0, 12));
         cfg_height = 16'($urandom_range(0, 12));
         cfg_raddr  = $urandom();
         cfg_waddr  = $urandom();
         s_hready   = ($urandom_range(0, 3) != 0);
      end
      n_rst = 1'b0; start = 1'b0; s_hready = 1'b1;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
